// File: rtl/mm_irq_pkg.sv
// Shared definitions for the memory-mapped interrupt generator: register map,
// IRQ bit positions, the valid pending mask and byte-enable helpers.
package mm_irq_pkg;

    localparam logic [2:0] REG_TCNT  = 3'd0;
    localparam logic [2:0] REG_TCMP  = 3'd1;
    localparam logic [2:0] REG_CTRL  = 3'd2;
    localparam logic [2:0] REG_SET   = 3'd3;
    localparam logic [2:0] REG_CLR   = 3'd4;
    localparam logic [2:0] REG_PEND  = 3'd5;
    localparam logic [2:0] REG_SMASK = 3'd6;
    localparam logic [2:0] REG_SDLY  = 3'd7;

    localparam int IRQ_SW      = 3;
    localparam int IRQ_TMR     = 7;
    localparam int IRQ_EXT     = 11;
    localparam int IRQ_FAST_LO = 16;
    localparam int IRQ_NMI     = 31;

    localparam logic [31:0] PEND_VALID_MASK = 32'hFFFF_0888;

    typedef enum logic {IDLE, ARMED} sched_state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        return (old_v & ~be_mask(be)) | (wd & be_mask(be));
    endfunction

endpackage

// File: rtl/mm_irq_timer.sv
// Free-running compare timer: TCNT/TCMP/enable registers with CPU write override
// and a one-cycle match event when the counter steps onto the compare value.
module mm_irq_timer
    import mm_irq_pkg::*;
#(
    parameter int TIMER_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_tcnt_i,
    input  logic        wr_tcmp_i,
    input  logic        wr_ctrl_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] tcnt_o,
    output logic [31:0] tcmp_o,
    output logic        en_o,
    output logic        evt_o
);

    logic [TIMER_WIDTH-1:0] tcnt_q, tcnt_d;
    logic [TIMER_WIDTH-1:0] tcmp_q, tcmp_d;
    logic                   en_q, en_d;

    always_comb begin
        tcnt_d = en_q ? tcnt_q + TIMER_WIDTH'(1) : tcnt_q;
        tcmp_d = tcmp_q;
        en_d   = en_q;
        if (wr_tcnt_i)
            tcnt_d = TIMER_WIDTH'(be_merge(32'(tcnt_q), wdata_i, be_i));
        if (wr_tcmp_i)
            tcmp_d = TIMER_WIDTH'(be_merge(32'(tcmp_q), wdata_i, be_i));
        if (wr_ctrl_i && be_i[0])
            en_d = wdata_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
            tcmp_q <= '0;
            en_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tcmp_q <= tcmp_d;
            en_q   <= en_d;
        end
    end

    // Event fires on the edge the counter lands on TCMP, so pend[7] rises with it.
    assign evt_o  = en_q && (tcnt_d == tcmp_q);
    assign tcnt_o = 32'(tcnt_q);
    assign tcmp_o = 32'(tcmp_q);
    assign en_o   = en_q;

endmodule

// File: rtl/mm_irq_gen.sv
// Memory-mapped interrupt stimulus generator: zero-wait-state slave port, pending
// register driving the core irq lines, delayed schedule FSM and compare timer.
module mm_irq_gen
    import mm_irq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    input  logic [4:0]            irq_id_i,
    input  logic                  irq_ack_i,
    output logic                  irq_software_o,
    output logic                  irq_timer_o,
    output logic                  irq_external_o,
    output logic [14:0]           irq_fast_o,
    output logic                  irq_nmi_o
);

    logic [2:0]  sel;
    logic        wr, rd;
    logic        unused_addr;
    logic [31:0] tcnt, tcmp;
    logic        tmr_en, tmr_evt;

    logic [31:0]  pend_q, pend_d;
    logic [31:0]  smask_q, smask_d;
    logic [31:0]  cnt_q, cnt_d;
    sched_state_e state_q, state_d;
    logic         sched_evt;
    logic         rvalid_q;
    logic [31:0]  rdata_q, rdata_d;
    logic [31:0]  set_w1s, clr_w1c, clr_ack;

    assign sel         = data_addr_i[4:2];
    assign wr          = data_req_i && data_we_i;
    assign rd          = data_req_i && !data_we_i;
    assign unused_addr = ^{data_addr_i[ADDR_WIDTH-1:5], data_addr_i[1:0]};
    assign data_gnt_o  = data_req_i;

    mm_irq_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_tcnt_i (wr && sel == REG_TCNT),
        .wr_tcmp_i (wr && sel == REG_TCMP),
        .wr_ctrl_i (wr && sel == REG_CTRL),
        .wdata_i   (data_wdata_i),
        .be_i      (data_be_i),
        .tcnt_o    (tcnt),
        .tcmp_o    (tcmp),
        .en_o      (tmr_en),
        .evt_o     (tmr_evt)
    );

    // Schedule FSM; a new SDLY write always restarts the countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sched_evt = 1'b0;
        if (wr && sel == REG_SDLY) begin
            state_d = ARMED;
            cnt_d   = be_merge(cnt_q, data_wdata_i, data_be_i);
        end else if (state_q == ARMED) begin
            if (cnt_q == 32'd0) begin
                sched_evt = 1'b1;
                state_d   = IDLE;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
    end

    // Sets are ORed in after the clears so a same-cycle set/clear keeps the bit.
    always_comb begin
        smask_d = (wr && sel == REG_SMASK) ? be_merge(smask_q, data_wdata_i, data_be_i)
                                           : smask_q;
        set_w1s = (wr && sel == REG_SET) ? (data_wdata_i & be_mask(data_be_i)) : 32'd0;
        clr_w1c = (wr && sel == REG_CLR) ? (data_wdata_i & be_mask(data_be_i)) : 32'd0;
        clr_ack = irq_ack_i ? (32'd1 << irq_id_i) : 32'd0;
        pend_d  = ((pend_q & ~clr_ack & ~clr_w1c)
                   | set_w1s
                   | (32'(tmr_evt) << IRQ_TMR)
                   | (sched_evt ? smask_d : 32'd0)) & PEND_VALID_MASK;
    end

    always_comb begin
        rdata_d = 32'd0;
        if (rd) begin
            case (sel)
                REG_TCNT:  rdata_d = tcnt;
                REG_TCMP:  rdata_d = tcmp;
                REG_CTRL:  rdata_d = {31'd0, tmr_en};
                REG_PEND:  rdata_d = pend_q;
                REG_SMASK: rdata_d = smask_q;
                REG_SDLY:  rdata_d = cnt_q;
                default:   rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q   <= '0;
            smask_q  <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            smask_q  <= smask_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            rvalid_q <= data_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign irq_software_o = pend_q[IRQ_SW];
    assign irq_timer_o    = pend_q[IRQ_TMR];
    assign irq_external_o = pend_q[IRQ_EXT];
    assign irq_fast_o     = pend_q[30:IRQ_FAST_LO];
    assign irq_nmi_o      = pend_q[IRQ_NMI];

endmodule

// File: tb/tb_mm_irq_gen.sv
// Directed self-checking bench for mm_irq_gen; expected values are hand-derived.
module tb_mm_irq_gen;
    import mm_irq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'hF;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic [4:0]  irq_id_i = '0;
    logic        irq_ack_i = 1'b0;
    logic        irq_software_o, irq_timer_o, irq_external_o, irq_nmi_o;
    logic [14:0] irq_fast_o;

    int errs = 0;
    int checks = 0;

    mm_irq_gen #(.ADDR_WIDTH(32), .TIMER_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .irq_id_i(irq_id_i), .irq_ack_i(irq_ack_i), .irq_software_o(irq_software_o),
        .irq_timer_o(irq_timer_o), .irq_external_o(irq_external_o),
        .irq_fast_o(irq_fast_o), .irq_nmi_o(irq_nmi_o)
    );

    always #5 clk_i = ~clk_i;

    // Bus tasks are entered 1ns after a rising edge and return 1ns after the grant edge.
    task automatic bus_wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] be = 4'hF);
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = {27'd0, r, 2'b00};
        data_be_i = be; data_wdata_i = d;
        @(posedge clk_i); #1;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
    endtask

    task automatic bus_rd(input logic [2:0] r, output logic [31:0] d, output logic v);
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = {27'd0, r, 2'b00};
        @(posedge clk_i); #1;
        d = data_rdata_o; v = data_rvalid_o;
        data_req_i = 1'b0;
    endtask

    task automatic do_ack(input logic [4:0] id);
        irq_id_i = id; irq_ack_i = 1'b1;
        @(posedge clk_i); #1;
        irq_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic v;
        data_req_i = 1'b1; data_addr_i = {27'd0, REG_PEND, 2'b00};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (data_rvalid_o !== 1'b0) begin
                errs++; $display("FAIL reset_rvalid[%0d]: got %b exp 0", i, data_rvalid_o);
            end
        end
        checks++;
        if ({irq_nmi_o, irq_fast_o, irq_external_o, irq_timer_o, irq_software_o} !== 19'd0) begin
            errs++; $display("FAIL reset_irqs: got %h exp 0",
                {irq_nmi_o, irq_fast_o, irq_external_o, irq_timer_o, irq_software_o});
        end
        rst_i = 1'b0; data_req_i = 1'b0;
        bus_rd(REG_PEND, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errs++; $display("FAIL reset_pend: got v=%b d=%h exp v=1 d=0", v, d);
        end
    endtask

    task automatic test_set_ack;
        logic [31:0] d; logic v;
        bus_wr(REG_SET, 32'h0000_0808);
        checks++;
        if (irq_software_o !== 1'b1 || irq_external_o !== 1'b1) begin
            errs++; $display("FAIL set_sw_ext: got sw=%b ext=%b exp 1 1", irq_software_o, irq_external_o);
        end
        do_ack(5'd3);
        checks++;
        if (irq_software_o !== 1'b0 || irq_external_o !== 1'b1) begin
            errs++; $display("FAIL ack3: got sw=%b ext=%b exp 0 1", irq_software_o, irq_external_o);
        end
        bus_rd(REG_PEND, d, v);
        checks++;
        if (d !== 32'h800) begin
            errs++; $display("FAIL ack3_pend: got %h exp 00000800", d);
        end
        bus_wr(REG_CLR, 32'hFFFF_FFFF);
    endtask

    task automatic test_timer;
        logic [31:0] d; logic v;
        bus_wr(REG_CTRL, 32'd0);
        bus_wr(REG_TCMP, 32'd20);
        bus_wr(REG_TCNT, 32'd0);
        bus_wr(REG_CTRL, 32'd1);
        repeat (19) @(posedge clk_i);
        #1;
        checks++;
        if (irq_timer_o !== 1'b0) begin
            errs++; $display("FAIL timer_early: got %b exp 0", irq_timer_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (irq_timer_o !== 1'b1) begin
            errs++; $display("FAIL timer_match: got %b exp 1", irq_timer_o);
        end
        bus_rd(REG_TCNT, d, v);
        checks++;
        if (d !== 32'd20) begin
            errs++; $display("FAIL timer_tcnt: got %0d exp 20", d);
        end
        bus_wr(REG_CTRL, 32'd0);
        bus_wr(REG_CLR, 32'h80);
        bus_wr(REG_TCNT, 32'hFFFF_FFFE);
        bus_wr(REG_TCMP, 32'd1);
        bus_wr(REG_CTRL, 32'd1);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk_i); #1;
            checks++;
            if (irq_timer_o !== 1'b0) begin
                errs++; $display("FAIL wrap_early[%0d]: got %b exp 0", k, irq_timer_o);
            end
        end
        @(posedge clk_i); #1;
        checks++;
        if (irq_timer_o !== 1'b1) begin
            errs++; $display("FAIL wrap_match: got %b exp 1", irq_timer_o);
        end
        bus_wr(REG_CTRL, 32'd0);
        bus_wr(REG_CLR, 32'hFFFF_FFFF);
    endtask

    task automatic test_sched;
        logic [31:0] d; logic v;
        bus_wr(REG_SMASK, 32'h8000_0000);
        bus_wr(REG_SDLY, 32'd10);
        repeat (10) @(posedge clk_i);
        #1;
        checks++;
        if (irq_nmi_o !== 1'b0) begin
            errs++; $display("FAIL sched_early: got %b exp 0", irq_nmi_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (irq_nmi_o !== 1'b1) begin
            errs++; $display("FAIL sched_fire: got %b exp 1", irq_nmi_o);
        end
        do_ack(5'd31);
        checks++;
        if (irq_nmi_o !== 1'b0) begin
            errs++; $display("FAIL sched_ack: got %b exp 0", irq_nmi_o);
        end
        bus_wr(REG_SDLY, 32'd10);
        for (int k = 1; k <= 7; k++) begin
            bus_rd(REG_SDLY, d, v);
            checks++;
            if (d !== 32'(11 - k)) begin
                errs++; $display("FAIL sdly_track[%0d]: got %0d exp %0d", k, d, 11 - k);
            end
        end
        bus_wr(REG_SDLY, 32'd5);
        bus_rd(REG_SDLY, d, v);
        checks++;
        if (d !== 32'd5) begin
            errs++; $display("FAIL sdly_rewrite: got %0d exp 5", d);
        end
        repeat (4) @(posedge clk_i);
        #1;
        checks++;
        if (irq_nmi_o !== 1'b0) begin
            errs++; $display("FAIL rewrite_early: got %b exp 0", irq_nmi_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (irq_nmi_o !== 1'b1) begin
            errs++; $display("FAIL rewrite_fire: got %b exp 1", irq_nmi_o);
        end
        bus_wr(REG_CLR, 32'hFFFF_FFFF);
    endtask

    task automatic test_same_cycle;
        logic [31:0] d; logic v;
        irq_id_i = 5'd16; irq_ack_i = 1'b1;
        bus_wr(REG_SET, 32'h0001_0000);
        irq_ack_i = 1'b0;
        checks++;
        if (irq_fast_o[0] !== 1'b1) begin
            errs++; $display("FAIL set_vs_ack: got %b exp 1", irq_fast_o[0]);
        end
        bus_wr(REG_CTRL, 32'd0);
        bus_wr(REG_TCNT, 32'd0);
        bus_wr(REG_TCMP, 32'd3);
        bus_wr(REG_CTRL, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        bus_wr(REG_CLR, 32'h0001_0000);
        checks++;
        if (irq_timer_o !== 1'b1 || irq_fast_o[0] !== 1'b0) begin
            errs++; $display("FAIL clr_vs_timer: got tmr=%b f16=%b exp 1 0", irq_timer_o, irq_fast_o[0]);
        end
        bus_rd(REG_PEND, d, v);
        checks++;
        if (d !== 32'h80) begin
            errs++; $display("FAIL clr_vs_timer_pend: got %h exp 00000080", d);
        end
        bus_wr(REG_CTRL, 32'd0);
        bus_wr(REG_CLR, 32'hFFFF_FFFF);
    endtask

    task automatic test_byte_en;
        logic [31:0] d; logic v;
        bus_wr(REG_SET, 32'hFFFF_FFFF);
        bus_rd(REG_PEND, d, v);
        checks++;
        if (d !== 32'hFFFF_0888) begin
            errs++; $display("FAIL valid_mask: got %h exp ffff0888", d);
        end
        bus_wr(REG_CLR, 32'hFFFF_FFFF);
        bus_wr(REG_SET, 32'hFFFF_FFFF, 4'b0100);
        bus_rd(REG_PEND, d, v);
        checks++;
        if (d !== 32'h00FF_0000 || irq_fast_o !== 15'h00FF) begin
            errs++; $display("FAIL be_set: got %h fast=%h exp 00ff0000 00ff", d, irq_fast_o);
        end
        do_ack(5'd5);
        bus_rd(REG_PEND, d, v);
        checks++;
        if (d !== 32'h00FF_0000) begin
            errs++; $display("FAIL bad_ack: got %h exp 00ff0000", d);
        end
        bus_wr(REG_SMASK, 32'h1234_5678);
        bus_wr(REG_SMASK, 32'hAABB_CCDD, 4'b0011);
        bus_rd(REG_SMASK, d, v);
        checks++;
        if (d !== 32'h1234_CCDD) begin
            errs++; $display("FAIL be_rw: got %h exp 1234ccdd", d);
        end
    endtask

    task automatic test_back_to_back;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = {27'd0, REG_SMASK, 2'b00};
        #1;
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errs++; $display("FAIL gnt_high: got %b exp 1", data_gnt_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h1234_CCDD) begin
            errs++; $display("FAIL b2b_rd0: got v=%b d=%h exp 1 1234ccdd", data_rvalid_o, data_rdata_o);
        end
        data_addr_i = {27'd0, REG_PEND, 2'b00};
        @(posedge clk_i); #1;
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h00FF_0000) begin
            errs++; $display("FAIL b2b_rd1: got v=%b d=%h exp 1 00ff0000", data_rvalid_o, data_rdata_o);
        end
        data_we_i = 1'b1; data_addr_i = {27'd0, REG_CLR, 2'b00}; data_wdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        checks++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'd0) begin
            errs++; $display("FAIL b2b_wr: got v=%b d=%h exp 1 0", data_rvalid_o, data_rdata_o);
        end
        data_req_i = 1'b0; data_we_i = 1'b0;
        #1;
        checks++;
        if (data_gnt_o !== 1'b0) begin
            errs++; $display("FAIL gnt_low: got %b exp 0", data_gnt_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'd0 || irq_fast_o !== 15'd0) begin
            errs++; $display("FAIL b2b_idle: got v=%b d=%h fast=%h exp 0 0 0",
                data_rvalid_o, data_rdata_o, irq_fast_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic v;
        bus_wr(REG_SMASK, 32'h8000_0000);
        bus_wr(REG_SET, 32'h8);
        bus_wr(REG_SDLY, 32'd3);
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = {27'd0, REG_PEND, 2'b00};
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'd0 || irq_software_o !== 1'b0) begin
            errs++; $display("FAIL reset_mid: got v=%b d=%h sw=%b exp 0 0 0",
                data_rvalid_o, data_rdata_o, irq_software_o);
        end
        rst_i = 1'b0; data_req_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        bus_rd(REG_SDLY, d, v);
        checks++;
        if (irq_nmi_o !== 1'b0 || d !== 32'd0) begin
            errs++; $display("FAIL reset_mid_sched: got nmi=%b sdly=%0d exp 0 0", irq_nmi_o, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set_ack();
        test_timer();
        test_sched();
        test_same_cycle();
        test_byte_en();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
